// File: rtl/bcd_multidigit_counter_if.sv
// Command and status bundle for the packed-BCD counter.
// The master drives commands; the slave (counter) drives count and flags.
interface bcd_multidigit_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  down;
    logic                  set9;
    logic                  set0;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  cout;
    logic                  bout;
    logic                  is_zero;
    logic                  is_max;
    logic                  illegal;

    modport master (
        output en, up, down, set9, set0, load, load_val,
        input  count, cout, bout, is_zero, is_max, illegal
    );

    modport slave (
        input  en, up, down, set9, set0, load, load_val,
        output count, cout, bout, is_zero, is_max, illegal
    );
endinterface

// File: rtl/bcd_multidigit_counter.sv
// N-digit packed-BCD up/down counter with wrap or saturate,
// set-to-max/zero, validated parallel load and cascade pulses.
module bcd_multidigit_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input logic clk,
    input logic rst_n,
    bcd_multidigit_counter_if.slave bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] MAX = {DIGITS{4'h9}};

    logic [W-1:0]      cnt_q;
    logic [W-1:0]      cnt_d;
    logic [W-1:0]      inc_v;
    logic [W-1:0]      dec_v;
    logic [DIGITS:0]   cy;
    logic [DIGITS:0]   bw;
    logic [DIGITS-1:0] dig_ok;
    logic [4:0]        cmd;
    logic              multi;
    logic              at_max;
    logic              at_zero;
    logic              cout_d;
    logic              bout_d;
    logic              ill_d;
    logic              cout_q;
    logic              bout_q;
    logic              ill_q;
    logic              zero_q;
    logic              max_q;

    assign cmd     = {bus.up, bus.down, bus.set9, bus.set0, bus.load};
    assign multi   = (cmd & (cmd - 5'd1)) != 5'd0;
    assign at_max  = cnt_q == MAX;
    assign at_zero = cnt_q == '0;

    // Ripple carry/borrow per digit: a digit changes only if all lower
    // digits rolled over.
    always_comb begin
        cy[0]  = 1'b1;
        bw[0]  = 1'b1;
        inc_v  = cnt_q;
        dec_v  = cnt_q;
        dig_ok = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_ok[i] = bus.load_val[4*i +: 4] <= 4'd9;
            cy[i+1] = cy[i] && (cnt_q[4*i +: 4] == 4'd9);
            bw[i+1] = bw[i] && (cnt_q[4*i +: 4] == 4'd0);
            if (cy[i])
                inc_v[4*i +: 4] = cy[i+1] ? 4'd0
                                          : cnt_q[4*i +: 4] + 4'd1;
            if (bw[i])
                dec_v[4*i +: 4] = bw[i+1] ? 4'd9
                                          : cnt_q[4*i +: 4] - 4'd1;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        cout_d = 1'b0;
        bout_d = 1'b0;
        ill_d  = 1'b0;
        if (bus.en && multi) begin
            ill_d = 1'b1;
        end else if (bus.en) begin
            unique case (1'b1)
                bus.up: begin
                    cout_d = at_max;
                    cnt_d  = at_max ? (WRAP ? '0 : MAX) : inc_v;
                end
                bus.down: begin
                    bout_d = at_zero;
                    cnt_d  = at_zero ? (WRAP ? MAX : '0) : dec_v;
                end
                bus.set9: cnt_d = MAX;
                bus.set0: cnt_d = '0;
                bus.load: begin
                    if (&dig_ok) cnt_d = bus.load_val;
                    else         ill_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            cout_q <= 1'b0;
            bout_q <= 1'b0;
            ill_q  <= 1'b0;
            zero_q <= 1'b1;
            max_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cout_q <= cout_d;
            bout_q <= bout_d;
            ill_q  <= ill_d;
            zero_q <= cnt_d == '0;
            max_q  <= cnt_d == MAX;
        end
    end

    assign bus.count   = cnt_q;
    assign bus.cout    = cout_q;
    assign bus.bout    = bout_q;
    assign bus.illegal = ill_q;
    assign bus.is_zero = zero_q;
    assign bus.is_max  = max_q;
endmodule

// File: tb/tb_bcd_multidigit_counter.sv
// Bench for bcd_multidigit_counter: 4-digit wrap, 4-digit saturate and
// 2-digit wrap instances against a decimal-integer reference model.
module tb_bcd_multidigit_counter;
    localparam logic [4:0] UP = 5'b10000;
    localparam logic [4:0] DN = 5'b01000;
    localparam logic [4:0] S9 = 5'b00100;
    localparam logic [4:0] S0 = 5'b00010;
    localparam logic [4:0] LD = 5'b00001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_multidigit_counter_if #(.DIGITS(4)) b4w ();
    bcd_multidigit_counter_if #(.DIGITS(4)) b4s ();
    bcd_multidigit_counter_if #(.DIGITS(2)) b2 ();

    bcd_multidigit_counter #(.DIGITS(4), .WRAP(1'b1)) u4w (
        .clk(clk), .rst_n(rst_n), .bus(b4w.slave)
    );
    bcd_multidigit_counter #(.DIGITS(4), .WRAP(1'b0)) u4s (
        .clk(clk), .rst_n(rst_n), .bus(b4s.slave)
    );
    bcd_multidigit_counter #(.DIGITS(2), .WRAP(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    assign b4s.en       = b4w.en;
    assign b4s.up       = b4w.up;
    assign b4s.down     = b4w.down;
    assign b4s.set9     = b4w.set9;
    assign b4s.set0     = b4w.set0;
    assign b4s.load     = b4w.load;
    assign b4s.load_val = b4w.load_val;

    int n_assert = 0;
    int n_fail   = 0;
    int m4w, m4s, m2;
    int n_cout, n_bout;

    function automatic logic [31:0] to_bcd(input int v, input int digits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [31:0] lv, input int digits);
        for (int i = 0; i < digits; i++)
            if (lv[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [31:0] lv, input int digits);
        int r, p;
        r = 0;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            r = r + int'(lv[4*i +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int max_of(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p - 1;
    endfunction

    // Reference: count held as a plain decimal integer.
    task automatic model(input int digits, input bit wrap, inout int v,
                         input bit e, input logic [4:0] c,
                         input logic [31:0] lv,
                         output bit co, output bit bo, output bit il);
        int mx, n;
        mx = max_of(digits);
        n  = int'(c[4]) + int'(c[3]) + int'(c[2]) + int'(c[1]) + int'(c[0]);
        co = 1'b0;
        bo = 1'b0;
        il = 1'b0;
        if (!e || n == 0) return;
        if (n > 1) begin
            il = 1'b1;
            return;
        end
        if (c == UP) begin
            if (v == mx) begin
                co = 1'b1;
                v  = wrap ? 0 : mx;
            end else v = v + 1;
        end else if (c == DN) begin
            if (v == 0) begin
                bo = 1'b1;
                v  = wrap ? mx : 0;
            end else v = v - 1;
        end else if (c == S9) v = mx;
        else if (c == S0) v = 0;
        else if (bcd_ok(lv, digits)) v = from_bcd(lv, digits);
        else il = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input int digits, input int m,
                            input bit co, input bit bo, input bit il,
                            input logic [31:0] cnt, input logic oc,
                            input logic ob, input logic oi,
                            input logic oz, input logic om);
        chk({nm, ".count"}, cnt, to_bcd(m, digits));
        chk({nm, ".cout"}, 32'(oc), 32'(co));
        chk({nm, ".bout"}, 32'(ob), 32'(bo));
        chk({nm, ".illegal"}, 32'(oi), 32'(il));
        chk({nm, ".is_zero"}, 32'(oz), 32'(m == 0));
        chk({nm, ".is_max"}, 32'(om), 32'(m == max_of(digits)));
    endtask

    task automatic check_all(input bit c1, input bit b1, input bit i1,
                             input bit c2, input bit b2_, input bit i2,
                             input bit c3, input bit b3, input bit i3);
        chk_inst("w4", 4, m4w, c1, b1, i1, 32'(b4w.count), b4w.cout,
                 b4w.bout, b4w.illegal, b4w.is_zero, b4w.is_max);
        chk_inst("s4", 4, m4s, c2, b2_, i2, 32'(b4s.count), b4s.cout,
                 b4s.bout, b4s.illegal, b4s.is_zero, b4s.is_max);
        chk_inst("w2", 2, m2, c3, b3, i3, 32'(b2.count), b2.cout,
                 b2.bout, b2.illegal, b2.is_zero, b2.is_max);
    endtask

    task automatic step(input bit e4, input logic [4:0] c4,
                        input logic [15:0] lv4, input bit e2,
                        input logic [4:0] c2, input logic [7:0] lv2);
        bit c1, b1, i1, c2o, b2o, i2, c3, b3, i3;
        b4w.en = e4;
        {b4w.up, b4w.down, b4w.set9, b4w.set0, b4w.load} = c4;
        b4w.load_val = lv4;
        b2.en = e2;
        {b2.up, b2.down, b2.set9, b2.set0, b2.load} = c2;
        b2.load_val = lv2;
        @(posedge clk);
        #1;
        model(4, 1'b1, m4w, e4, c4, 32'(lv4), c1, b1, i1);
        model(4, 1'b0, m4s, e4, c4, 32'(lv4), c2o, b2o, i2);
        model(2, 1'b1, m2, e2, c2, 32'(lv2), c3, b3, i3);
        if (c3) n_cout++;
        if (b3) n_bout++;
        check_all(c1, b1, i1, c2o, b2o, i2, c3, b3, i3);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m4w = 0;
        m4s = 0;
        m2  = 0;
        check_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] rnd_cmd();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 5'b0;
        if (r <= 5) return 5'(1 << (r - 1));
        if (r <= 7) return UP;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst_n = 1'b0;
        b4w.en = 1'b0;
        {b4w.up, b4w.down, b4w.set9, b4w.set0, b4w.load} = 5'b0;
        b4w.load_val = '0;
        b2.en = 1'b0;
        {b2.up, b2.down, b2.set9, b2.set0, b2.load} = 5'b0;
        b2.load_val = '0;
        m4w = 0;
        m4s = 0;
        m2  = 0;
        n_cout = 0;
        n_bout = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        step(1, 5'b0, 16'h0, 1, 5'b0, 8'h0);
        step(1, LD, 16'h1234, 1, LD, 8'h42);
        mid_reset();
        step(1, 5'b0, 16'h0, 1, 5'b0, 8'h0);
        step(1, 5'b0, 16'h0, 1, 5'b0, 8'h0);

        step(1, LD, 16'h0999, 1, LD, 8'h09);
        step(1, UP, 16'h0, 1, UP, 8'h0);
        step(1, LD, 16'h9999, 1, LD, 8'h99);
        step(1, UP, 16'h0, 1, UP, 8'h0);
        step(1, UP, 16'h0, 1, UP, 8'h0);
        step(1, UP, 16'h0, 1, 5'b0, 8'h0);
        step(1, 5'b0, 16'h0, 1, 5'b0, 8'h0);

        step(1, LD, 16'h1000, 1, LD, 8'h10);
        step(1, DN, 16'h0, 1, DN, 8'h0);
        step(1, S0, 16'h0, 1, S0, 8'h0);
        step(1, DN, 16'h0, 1, DN, 8'h0);
        step(1, DN, 16'h0, 1, 5'b0, 8'h0);
        step(1, 5'b0, 16'h0, 1, 5'b0, 8'h0);

        step(1, LD, 16'h12A4, 1, LD, 8'h3F);
        step(1, LD, 16'h5678, 1, LD, 8'h56);
        step(1, UP | DN, 16'h0, 1, S9 | S0, 8'h0);
        step(0, S9, 16'h0, 0, S9, 8'h0);
        step(0, UP | DN, 16'h0, 0, LD, 8'hAA);
        step(1, S9, 16'h0, 1, S9, 8'h0);
        step(1, UP, 16'h0, 1, UP, 8'h0);
        mid_reset();
        step(1, S9, 16'h0, 1, S9, 8'h0);
        step(1, S0, 16'h0, 1, S0, 8'h0);

        for (int k = 0; k < 400; k++) begin
            logic [15:0] lv4;
            logic [7:0]  lv2;
            lv4 = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                  : 16'(to_bcd(int'($urandom_range(0, 9999)), 4));
            lv2 = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                  : 8'(to_bcd(int'($urandom_range(0, 99)), 2));
            step($urandom_range(0, 7) != 0, rnd_cmd(), lv4,
                 $urandom_range(0, 7) != 0, rnd_cmd(), lv2);
        end

        step(0, 5'b0, 16'h0, 1, S0, 8'h0);
        n_cout = 0;
        for (int k = 0; k < 100; k++)
            step(0, 5'b0, 16'h0, 1, UP, 8'h0);
        chk("w2.sweep_up_couts", 32'(n_cout), 32'd1);
        chk("w2.sweep_up_end", 32'(b2.count), 32'h00);
        n_bout = 0;
        for (int k = 0; k < 100; k++)
            step(0, 5'b0, 16'h0, 1, DN, 8'h0);
        chk("w2.sweep_dn_bouts", 32'(n_bout), 32'd1);
        chk("w2.sweep_dn_end", 32'(b2.count), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_multidigit_counter.md
# bcd_multidigit_counter

Parametrised N-digit packed-BCD up/down counter with synchronous set-to-max, set-to-zero and parallel load, selectable wrap or saturate behaviour, and registered carry/borrow pulses for cascading. It generalises the single-digit BCD up/down counter used on the lab display datapath to multi-digit counts such as seconds/minutes and event tallies driving 7-segment scanners. All state changes happen on the rising clock edge; only reset is asynchronous.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS bits, digit 0 in bits [3:0].
- WRAP, 1, 1 = wrap (max+1 -> 0, 0-1 -> max); 0 = saturate at max/0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  command qualifier; when 0 all commands ignored, state held, pulses 0.
- up  input  1  increment by 1.
- down  input  1  decrement by 1.
- set9  input  1  all digits to 9.
- set0  input  1  all digits to 0.
- load  input  1  load load_val.
- load_val  input  4*DIGITS  packed BCD value for load.
- count  output  4*DIGITS  registered packed BCD count.
- cout  output  1  registered one-cycle pulse: increment attempted at max.
- bout  output  1  registered one-cycle pulse: decrement attempted at 0.
- is_zero  output  1  registered, count == all zeros.
- is_max  output  1  registered, count == all nines.
- illegal  output  1  registered one-cycle pulse: rejected command.

## Operation
- Reset (rst_n low, any time, independent of clk): count = 0, cout = 0, bout = 0, illegal = 0, is_zero = 1, is_max = 0. Held while rst_n low.
- Command vector {up, down, set9, set0, load} is sampled when en = 1 and must be one-hot or all-zero.
  - All-zero: hold; pulses 0.
  - More than one bit set: hold count, illegal = 1 for one cycle.
- up: digit-wise BCD increment; digit 0 increments, each digit that was 9 becomes 0 and carries to the next. At max (all 9): WRAP=1 -> count = 0, cout = 1; WRAP=0 -> count held at max, cout = 1.
- down: digit-wise BCD decrement; each digit that was 0 becomes 9 and borrows. At 0: WRAP=1 -> count = max, bout = 1; WRAP=0 -> count held at 0, bout = 1.
- set9: all digits 9. set0: all digits 0. Neither pulses cout/bout.
- load: if every digit of load_val is 0..9, count = load_val; if any digit is A..F, whole load rejected, count held, illegal = 1.
- cout, bout, illegal are 0 in every cycle not listed above; at most one of them is 1 in a cycle.
- is_zero/is_max always reflect the registered count in the same cycle, including after reset, set, load and wrap.
- Count never holds a non-BCD digit under any input sequence.

## Timing
- Latency 1: command sampled at edge k, new count, pulses and flags valid after edge k and held until edge k+1.
- Pulses are exactly one cycle wide. Repeated up at max in WRAP=0 gives cout = 1 on every such cycle.
- Cascading: cout/bout are aligned with the count update, so a downstream stage driving its up from cout advances one cycle later. Per-stage latency of 1 is accepted.
- rst_n deassertion is synchronous to clk in the system. The first command is honoured at the first rising edge with rst_n high.
- rst_n asserted mid-operation clears all outputs immediately, including a pulse in progress.
- en = 0 with commands asserted: no state change, no illegal pulse.

## Test plan
- Reset/idle: DIGITS=4, assert rst_n low mid-count at 0x1234 -> count = 0x0000, is_zero = 1 immediately; release, no commands -> count holds 0x0000.
- Increment ripple: load 0x0999, up -> 0x1000, cout = 0. Load 0x9999, up with WRAP=1 -> 0x0000, cout = 1 for exactly one cycle, is_zero = 1.
- Decrement ripple/saturate: load 0x1000, down -> 0x0999. Count 0x0000, down with WRAP=0 -> stays 0x0000, bout = 1. With WRAP=1 -> 0x9999, bout = 1, is_max = 1.
- Load validation: load 0x12A4 -> count unchanged, illegal = 1. Load 0x5678 -> 0x5678, illegal = 0.
- Command conflicts: up and down together -> hold, illegal = 1. set9 with en = 0 -> hold, illegal = 0. set9 -> 0x9999, is_max = 1, cout = 0.
- Exhaustive sweep: DIGITS=2, WRAP=1, 100 ups from 00 -> every value 00..99 visited in order, back to 00, single cout. Repeat with 100 downs, single bout.
